// File: rtl/rv_exe_pkg.sv
// Shared encodings for the RV32IM execute stage: ALU ops, funct3 decodes,
// forwarding selects and the mul/div FSM state type.
package rv_exe_pkg;

  localparam logic [3:0] AluAdd   = 4'd0;
  localparam logic [3:0] AluSub   = 4'd1;
  localparam logic [3:0] AluAnd   = 4'd2;
  localparam logic [3:0] AluOr    = 4'd3;
  localparam logic [3:0] AluXor   = 4'd4;
  localparam logic [3:0] AluSlt   = 4'd5;
  localparam logic [3:0] AluSltu  = 4'd6;
  localparam logic [3:0] AluSll   = 4'd7;
  localparam logic [3:0] AluSrl   = 4'd8;
  localparam logic [3:0] AluSra   = 4'd9;
  localparam logic [3:0] AluPassB = 4'd10;

  localparam logic [2:0] BrEq  = 3'b000;
  localparam logic [2:0] BrNe  = 3'b001;
  localparam logic [2:0] BrLt  = 3'b100;
  localparam logic [2:0] BrGe  = 3'b101;
  localparam logic [2:0] BrLtu = 3'b110;
  localparam logic [2:0] BrGeu = 3'b111;

  localparam logic [2:0] MdMul    = 3'b000;
  localparam logic [2:0] MdMulh   = 3'b001;
  localparam logic [2:0] MdMulhsu = 3'b010;
  localparam logic [2:0] MdMulhu  = 3'b011;
  localparam logic [2:0] MdDiv    = 3'b100;
  localparam logic [2:0] MdDivu   = 3'b101;
  localparam logic [2:0] MdRem    = 3'b110;
  localparam logic [2:0] MdRemu   = 3'b111;

  localparam logic [1:0] FwdRd = 2'b00;
  localparam logic [1:0] FwdW  = 2'b01;
  localparam logic [1:0] FwdM  = 2'b10;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} mdState_e;

endpackage

// File: rtl/muldiv_unit.sv
// Multi-cycle M-extension engine: one-cycle registered multiply and a
// restoring radix-2 divider on operand magnitudes with final sign fix-up.
module muldiv_unit
  import rv_exe_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             validE,
  input  logic             mulDivE,
  input  logic             flushE,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic [2:0]       funct3,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy
);

  mdState_e               stateQ, stateD;
  logic [WIDTH-1:0]       aQ, aD, bQ, bD, quotQ, quotD, remQ, remD;
  logic [2*WIDTH-1:0]     prodQ, prodD;
  logic [2:0]             opQ, opD;
  logic [5:0]             cntQ, cntD;
  logic                   negQuotQ, negQuotD, negRemQ, negRemD;

  logic                   start, opSigned, divByZero, overflow;
  logic [WIDTH-1:0]       absA, divisorMag;
  logic [2*WIDTH-1:0]     aExt, bExt, prod;
  logic [WIDTH:0]         remShift, diff;
  logic                   qBit;
  logic [WIDTH-1:0]       remNext, quotNext;
  logic                   busyRaw;

  assign start     = validE & mulDivE & ~flushE;
  assign opSigned  = ~funct3[0];
  assign absA      = (opSigned & srcA[WIDTH-1]) ? -srcA : srcA;
  assign divByZero = (srcB == '0);
  assign overflow  = opSigned & (srcA == {1'b1, {(WIDTH-1){1'b0}}}) & (srcB == '1);

  // Zero/sign-extend to 2*WIDTH so the low half of a plain product is exact.
  assign aExt = (opQ == MdMulh || opQ == MdMulhsu) ? {{WIDTH{aQ[WIDTH-1]}}, aQ}
                                                    : {{WIDTH{1'b0}}, aQ};
  assign bExt = (opQ == MdMulh) ? {{WIDTH{bQ[WIDTH-1]}}, bQ} : {{WIDTH{1'b0}}, bQ};
  assign prod = aExt * bExt;

  assign divisorMag = (~opQ[0] & bQ[WIDTH-1]) ? -bQ : bQ;
  assign remShift   = {remQ, quotQ[WIDTH-1]};
  assign diff       = remShift - {1'b0, divisorMag};
  assign qBit       = ~diff[WIDTH];
  assign remNext    = qBit ? diff[WIDTH-1:0] : remShift[WIDTH-1:0];
  assign quotNext   = {quotQ[WIDTH-2:0], qBit};

  always_comb begin
    stateD   = stateQ;
    aD       = aQ;
    bD       = bQ;
    opD      = opQ;
    prodD    = prodQ;
    quotD    = quotQ;
    remD     = remQ;
    cntD     = cntQ;
    negQuotD = negQuotQ;
    negRemD  = negRemQ;
    busyRaw  = 1'b0;
    case (stateQ)
      StIdle: begin
        if (start) begin
          busyRaw = 1'b1;
          aD      = srcA;
          bD      = srcB;
          opD     = funct3;
          if (!funct3[2]) begin
            stateD = StMul;
          end else if (divByZero) begin
            quotD  = '1;
            remD   = srcA;
            stateD = StDone;
          end else if (overflow) begin
            quotD  = {1'b1, {(WIDTH-1){1'b0}}};
            remD   = '0;
            stateD = StDone;
          end else begin
            quotD    = absA;
            remD     = '0;
            cntD     = '0;
            negQuotD = opSigned & (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
            negRemD  = opSigned & srcA[WIDTH-1];
            stateD   = StDiv;
          end
        end
      end
      StMul: begin
        busyRaw = 1'b1;
        prodD   = prod;
        stateD  = StDone;
      end
      StDiv: begin
        busyRaw = 1'b1;
        quotD   = quotNext;
        remD    = remNext;
        cntD    = cntQ + 6'd1;
        if (cntQ == 6'(DIV_CYCLES - 1)) begin
          quotD  = negQuotQ ? -quotNext : quotNext;
          remD   = negRemQ ? -remNext : remNext;
          stateD = StDone;
        end
      end
      StDone:  stateD = StIdle;
      default: stateD = StIdle;
    endcase
    if (stateQ != StIdle && flushE) stateD = StIdle;
  end

  // Gated by reset so the stall request drops the instant reset asserts.
  assign busy = busyRaw & RST_N;
  assign done = (stateQ == StDone);

  always_comb begin
    case (opQ)
      MdMul:                    result = prodQ[WIDTH-1:0];
      MdMulh, MdMulhsu, MdMulhu: result = prodQ[2*WIDTH-1:WIDTH];
      MdDiv, MdDivu:            result = quotQ;
      default:                  result = remQ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stateQ   <= StIdle;
      aQ       <= '0;
      bQ       <= '0;
      opQ      <= '0;
      prodQ    <= '0;
      quotQ    <= '0;
      remQ     <= '0;
      cntQ     <= '0;
      negQuotQ <= 1'b0;
      negRemQ  <= 1'b0;
    end else begin
      stateQ   <= stateD;
      aQ       <= aD;
      bQ       <= bD;
      opQ      <= opD;
      prodQ    <= prodD;
      quotQ    <= quotD;
      remQ     <= remD;
      cntQ     <= cntD;
      negQuotQ <= negQuotD;
      negRemQ  <= negRemD;
    end
  end

endmodule

// File: rtl/execute_stage.sv
// RV32IM execute stage: operand forwarding, ALU, branch resolution, jump
// target and the stalling mul/div engine.
module execute_stage
  import rv_exe_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ValidE,
  input  logic             FlushE,
  input  logic [WIDTH-1:0] RD1E,
  input  logic [WIDTH-1:0] RD2E,
  input  logic [WIDTH-1:0] ImmExtE,
  input  logic [WIDTH-1:0] PCE,
  input  logic [3:0]       ALUControlE,
  input  logic             ALUSrcE,
  input  logic [2:0]       Funct3E,
  input  logic             MulDivE,
  input  logic             BranchE,
  input  logic             JumpE,
  input  logic             JumpRegE,
  input  logic [1:0]       ForwardAE,
  input  logic [1:0]       ForwardBE,
  input  logic [WIDTH-1:0] ResultW,
  input  logic [WIDTH-1:0] ALUResultM,
  output logic [WIDTH-1:0] ALUResultE,
  output logic [WIDTH-1:0] WriteDataE,
  output logic [WIDTH-1:0] PCTargetE,
  output logic             PCSrcE,
  output logic             BusyE
);

  logic [WIDTH-1:0] srcAE, srcBE, aluResult, mdResult, jalrSum;
  logic [4:0]       shamt;
  logic             mdDone, eq, lt, ltu, taken;

  always_comb begin
    case (ForwardAE)
      FwdW:    srcAE = ResultW;
      FwdM:    srcAE = ALUResultM;
      default: srcAE = RD1E;
    endcase
    case (ForwardBE)
      FwdW:    WriteDataE = ResultW;
      FwdM:    WriteDataE = ALUResultM;
      default: WriteDataE = RD2E;
    endcase
  end

  assign srcBE = ALUSrcE ? ImmExtE : WriteDataE;
  assign shamt = srcBE[4:0];
  assign eq    = (srcAE == srcBE);
  assign lt    = ($signed(srcAE) < $signed(srcBE));
  assign ltu   = (srcAE < srcBE);

  always_comb begin
    case (ALUControlE)
      AluSub:   aluResult = srcAE - srcBE;
      AluAnd:   aluResult = srcAE & srcBE;
      AluOr:    aluResult = srcAE | srcBE;
      AluXor:   aluResult = srcAE ^ srcBE;
      AluSlt:   aluResult = {{(WIDTH-1){1'b0}}, lt};
      AluSltu:  aluResult = {{(WIDTH-1){1'b0}}, ltu};
      AluSll:   aluResult = srcAE << shamt;
      AluSrl:   aluResult = srcAE >> shamt;
      AluSra:   aluResult = $signed(srcAE) >>> shamt;
      AluPassB: aluResult = srcBE;
      default:  aluResult = srcAE + srcBE;
    endcase
  end

  always_comb begin
    case (Funct3E)
      BrEq:    taken = eq;
      BrNe:    taken = ~eq;
      BrLt:    taken = lt;
      BrGe:    taken = ~lt;
      BrLtu:   taken = ltu;
      BrGeu:   taken = ~ltu;
      default: taken = 1'b0;
    endcase
  end

  assign PCSrcE    = RST_N & ValidE & (JumpE | (BranchE & taken));
  assign jalrSum   = srcAE + ImmExtE;
  assign PCTargetE = JumpRegE ? {jalrSum[WIDTH-1:1], 1'b0} : PCE + ImmExtE;

  muldiv_unit #(
    .WIDTH      (WIDTH),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_muldiv (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .validE  (ValidE),
    .mulDivE (MulDivE),
    .flushE  (FlushE),
    .srcA    (srcAE),
    .srcB    (WriteDataE),
    .funct3  (Funct3E),
    .result  (mdResult),
    .done    (mdDone),
    .busy    (BusyE)
  );

  assign ALUResultE = mdDone ? mdResult : aluResult;

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
Execute stage of the 5-stage RV32IM pipeline. It consumes the decode→execute pipeline register outputs and does the following:
- applies operand forwarding;
- computes the ALU result, branch decision and PC target;
- runs a multi-cycle multiply/divide engine (M extension), asserting BusyE to stall the pipeline while it is busy.

Its outputs feed the execute→memory pipeline register and the hazard unit.

Parameters:
WIDTH, 32, datapath width
DIV_CYCLES, 32, radix-2 divide iterations (must equal WIDTH)

Ports:
CLK  input  1  clock
RST_N  input  1  asynchronous active-low reset
ValidE  input  1  E holds a real instruction (0 = bubble)
FlushE  input  1  hazard-unit flush of E
RD1E  input  WIDTH  register operand A
RD2E  input  WIDTH  register operand B
ImmExtE  input  WIDTH  extended immediate
PCE  input  WIDTH  instruction PC
ALUControlE  input  4  ALU op (package encoding)
ALUSrcE  input  1  1 = SrcB is ImmExtE
Funct3E  input  3  branch condition / M-op select
MulDivE  input  1  instruction is an M-extension op
BranchE  input  1  conditional branch
JumpE  input  1  unconditional jump
JumpRegE  input  1  JALR target
ForwardAE  input  2  00 RD1E, 01 ResultW, 10 ALUResultM
ForwardBE  input  2  same, for RD2E
ResultW  input  WIDTH  writeback forward value
ALUResultM  input  WIDTH  memory-stage forward value
ALUResultE  output  WIDTH  ALU or M-op result
WriteDataE  output  WIDTH  forwarded operand B (store data)
PCTargetE  output  WIDTH  branch/jump target
PCSrcE  output  1  redirect fetch
BusyE  output  1  stall request to hazard unit

Behaviour:
- Reset (RST_N=0, asynchronous): FSM to IDLE; operand, product, quotient, remainder and counter registers cleared. Outputs during reset: BusyE=0, PCSrcE=0. ALUResultE, WriteDataE and PCTargetE follow their combinational definitions with cleared internal state.
- Forwarding mux:
  - SrcAE = mux(ForwardAE).
  - WriteDataE = mux(ForwardBE).
  - SrcBE = ALUSrcE ? ImmExtE : WriteDataE.
  - Code 11 selects RD*E.
- ALU (combinational, non-M): ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA, PASSB.
  - Shift amount is SrcBE[4:0].
  - All arithmetic wraps modulo 2^WIDTH.
- Branch condition by Funct3E: 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU; 010/011 never taken.
- PCSrcE = ValidE & (JumpE | (BranchE & taken)).
- PCTargetE:
  - JumpRegE=1: (SrcAE+ImmExtE) with bit0 cleared.
  - Otherwise: PCE+ImmExtE.
- M-op select by Funct3E: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: if ValidE & MulDivE & !FlushE, start. Latch SrcAE, WriteDataE and Funct3E, then go to MUL or DIV. BusyE=1 combinationally in the start cycle.
  - Divide special cases bypass DIV and go straight to DONE:
    - Divisor 0: quotient all-ones, remainder = dividend.
    - Signed overflow (0x80000000 / -1): quotient 0x80000000, remainder 0.
  - MUL: one cycle; registers the 2*WIDTH product, signedness per op; goes to DONE. BusyE=1.
  - DIV: restoring radix-2 on magnitudes, DIV_CYCLES iterations counted by a 6-bit counter. The final iteration applies sign correction: quotient negated if signs differ, remainder takes the dividend sign. Goes to DONE. BusyE=1 throughout.
  - DONE: BusyE=0; ALUResultE = selected low/high product, quotient or remainder; goes to IDLE unconditionally, so the same instruction never restarts.
- Latency from the start cycle (cycle 0):
  - MUL family: busy in cycles 0–1, result in cycle 2.
  - DIV/REM: busy in cycles 0–32, result in cycle 33.
  - Special-case divide: busy in cycle 0, result in cycle 1.
- Latched operands isolate the engine from forwarding changes during a stall.
- FlushE in any non-IDLE state: abort to IDLE on the next edge; BusyE=0 from that edge; no result produced.
- Bubble (ValidE=0) with MulDivE=1 never starts the engine.
- Reset mid-operation: immediate return to IDLE; BusyE deasserted asynchronously.

Decomposition:
- Package rv_exe_pkg: ALUControl encoding localparams, Funct3 branch and M-op constants, forwarding-select constants, FSM state enum.
- One sub-module, muldiv_unit, holds the FSM, counter and datapath registers. execute_stage holds the forwarding muxes, ALU, branch compare and target adder.

Test Plan:
- ADD with ForwardAE=10, ALUResultM=5, RD2E=7 -> ALUResultE=12, BusyE=0 in the same cycle.
- BLT with SrcA=-1, SrcB=1, ValidE=1 -> PCSrcE=1, PCTargetE=PCE+ImmExtE. Same with ValidE=0 -> PCSrcE=0.
- JALR with SrcA=0x1001, Imm=4 -> PCTargetE=0x1004, PCSrcE=1.
- MULH of 0x80000000 × 0x80000000 -> BusyE high for 2 cycles, then ALUResultE=0x40000000. MULHU of 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV -7/2 -> 33 busy cycles, then -3. REM -7/2 -> -1. DIVU x/0 -> 0xFFFFFFFF after 1 busy cycle. DIV 0x80000000/-1 -> 0x80000000.
- DIV started, FlushE at cycle 10 -> BusyE=0 from cycle 11, FSM in IDLE. Reset asserted at cycle 5 of a DIV -> BusyE drops immediately; a fresh DIV then completes correctly.
